// File: rtl/vram_fetch_arbiter.sv
// Arbitrates the text VRAM between a one-word-ahead raster prefetch (never stalled) and a CPU port.
// CPU latency is 3 cycles from grant to ack, plus 1 cycle when it collides with a video fetch.
module vram_fetch_arbiter #(
  parameter int H_TOTAL       = 800,
  parameter int V_TOTAL       = 525,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int WORDS_PER_ROW = 20,
  parameter int ADDR_W        = 10
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [31:0]       vram_wdata,
  input  logic [31:0]       vram_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic [7:0]        code
);

  localparam int LINE_START_X = H_TOTAL - 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } port_t;

  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_CAPT, C_ACK} cpu_state_t;

  cpu_state_t        state;
  logic              op_we;
  port_t             port;
  logic [1:0]        fetch_vld;
  logic [31:0]       next_word;
  logic [31:0]       cur_word;

  logic [9:0]        next_line;
  logic [4:0]        grp;
  logic              mid_trig;
  logic              line_trig;
  logic              vid_trig;
  logic              cpu_grant;
  logic              swap;
  logic [ADDR_W-1:0] vid_addr;

  // row * 20 built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] row);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 4) + (r << 2);
  endfunction

  always_comb begin
    grp       = DrawX[9:5];
    next_line = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    mid_trig  = (DrawY < 10'(V_ACTIVE)) && (DrawX < 10'(H_ACTIVE - 32)) &&
                (DrawX[4:0] == 5'd0) && (32'(grp) < 32'(WORDS_PER_ROW - 1));
    line_trig = (DrawX == 10'(LINE_START_X)) && (next_line < 10'(V_ACTIVE));
    vid_trig  = mid_trig || line_trig;
    vid_addr  = mid_trig ? row_base(DrawY[9:4]) + ADDR_W'(grp) + ADDR_W'(1)
                         : row_base(next_line[9:4]);
    cpu_grant = (state == C_IDLE) && cpu_req && !vid_trig;
    swap      = ((DrawX[4:0] == 5'd31) && (DrawX < 10'(H_ACTIVE))) ||
                (DrawX == 10'(H_TOTAL - 1));
  end

  assign vram_addr  = port.addr;
  assign vram_we    = port.we;
  assign vram_wdata = port.wdata;
  assign code       = cur_word[{DrawX[4:3], 3'b000} +: 8];

  // VRAM port and video double buffer; fetch_vld tracks a video read through the RAM latency
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      port      <= '0;
      fetch_vld <= '0;
      next_word <= '0;
      cur_word  <= '0;
    end else begin
      port.we <= 1'b0;
      if (vid_trig) begin
        port.addr <= vid_addr;
      end else if (cpu_grant) begin
        port.addr <= cpu_addr;
        port.we   <= cpu_we;
        if (cpu_we) port.wdata <= cpu_wdata;
      end
      fetch_vld <= {fetch_vld[0], vid_trig};
      if (fetch_vld[1]) next_word <= vram_rdata;
      if (swap) cur_word <= next_word;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state     <= C_IDLE;
      op_we     <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        C_IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_grant) begin
            state <= C_ISSUE;
            op_we <= cpu_we;
          end
        end
        C_ISSUE: state <= C_CAPT;
        C_CAPT: begin
          state   <= C_ACK;
          cpu_ack <= 1'b1;
          if (!op_we) cpu_rdata <= vram_rdata;
        end
        C_ACK: begin
          // request still held here is deliberately not re-granted
          state   <= C_IDLE;
          cpu_ack <= 1'b0;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter with a synchronous VRAM model and a CPU-transaction scoreboard.
module tb_vram_fetch_arbiter;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  vram_addr;
  logic        vram_we;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [7:0]  code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  addr_seen  [1:8];
  logic        we_seen    [1:8];
  logic [31:0] wdata_seen [1:8];
  logic [31:0] mem [0:1023];

  vram_fetch_arbiter dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .code       (code)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'd0:   return 32'h4443_4241;
      10'd1:   return 32'h4847_4645;
      10'd2:   return 32'h4C4B_4A49;
      default: return {4{a[7:0]}};
    endcase
  endfunction

  // Single-port synchronous VRAM: data for an address appears the cycle after it is presented
  always @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    if (DrawX == 10'd799) begin
      DrawX = 10'd0;
      DrawY = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
    end else begin
      DrawX = DrawX + 10'd1;
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    adv();
    #1;
  endtask

  task automatic jump(input logic [9:0] y, input logic [9:0] x);
    DrawY = y;
    DrawX = x;
    #1;
  endtask

  task automatic run_to(input logic [9:0] y, input logic [9:0] x);
    for (int i = 0; i < 1000; i++) begin
      if (DrawY == y && DrawX == x) break;
      tick();
    end
  endtask

  // Raise a request in the current cycle, record the port each cycle, and score the ack
  task automatic cpu_op(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata, input string tag);
    exp_t e;
    int   n;
    logic got;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    e.lat   = lat;
    e.rd    = !we;
    e.rdata = rdata;
    exp_q.push_back(e);
    got = 1'b0;
    n   = 0;
    while (!got && n < 8) begin
      tick();
      n++;
      addr_seen[n]  = vram_addr;
      we_seen[n]    = vram_we;
      wdata_seen[n] = vram_wdata;
      got           = cpu_ack;
    end
    e = exp_q.pop_front();
    chk({tag, "_ack_latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(e.lat));
    if (e.rd) chk({tag, "_rdata"}, cpu_rdata, e.rdata);
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0;
    w0        = 32'h4443_4241;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    DrawY     = 10'd100;
    DrawX     = 10'd298;

    // Reset held two cycles mid-frame
    tick();
    tick();
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    chk("rst_vram_wdata", vram_wdata, 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_code", 32'(code), 32'h00);
    reset = 1'b0;
    cpu_op(1'b0, 10'd7, 32'd0, 3, 32'h0707_0707, "first_rd");
    chk("first_rd_addr", 32'(addr_seen[1]), 32'd7);

    // Line-start prefetch for line 0, then the mid-line chain
    jump(10'd524, 10'd780);
    run_to(10'd524, 10'd784);
    tick();
    chk("ls_addr", 32'(vram_addr), 32'd0);
    chk("ls_we", 32'(vram_we), 32'd0);
    run_to(10'd0, 10'd0);
    for (int x = 0; x < 32; x++) begin
      chk("ln0_code", 32'(code), 32'(w0[{DrawX[4:3], 3'b000} +: 8]));
      if (x == 1) chk("mid_addr", 32'(vram_addr), 32'd1);
      tick();
    end
    chk("ln0_code_x32", 32'(code), 32'h45);

    // Collision: CPU write raised with the DrawX=32 fetch
    cpu_op(1'b1, 10'd5, 32'hDEAD_BEEF, 4, 32'd0, "coll_wr");
    chk("coll_vid_addr", 32'(addr_seen[1]), 32'd2);
    chk("coll_vid_we", 32'(we_seen[1]), 32'd0);
    chk("coll_cpu_addr", 32'(addr_seen[2]), 32'd5);
    chk("coll_cpu_we", 32'(we_seen[2]), 32'd1);
    chk("coll_cpu_wdata", wdata_seen[2], 32'hDEAD_BEEF);
    chk("coll_we_pulse", 32'(we_seen[3]), 32'd0);
    chk("ln0_code_x37", 32'(code), 32'h45);

    // Row addressing
    jump(10'd16, 10'd0);
    tick();
    chk("row1_mid_addr", 32'(vram_addr), 32'd21);
    jump(10'd16, 10'd784);
    tick();
    chk("row1_start_addr", 32'(vram_addr), 32'd20);
    run_to(10'd17, 10'd0);
    chk("row1_code", 32'(code), 32'h14);
    jump(10'd479, 10'd784);
    tick();
    chk("no_fetch_479_addr", 32'(vram_addr), 32'd20);
    chk("no_fetch_479_we", 32'(vram_we), 32'd0);

    // CPU read during vertical blanking, request held through the ack
    jump(10'd500, 10'd100);
    cpu_op(1'b0, 10'd5, 32'd0, 3, 32'hDEAD_BEEF, "blank_rd");
    chk("blank_rd_addr", 32'(addr_seen[1]), 32'd5);
    chk("blank_rd_we", 32'(we_seen[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_regrant_ack", 32'(cpu_ack), 32'd0);
    end
    chk("blank_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

    // Reset while the FSM is in C_CAPT
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    cpu_req = 1'b0;
    chk("midrst_ack", 32'(cpu_ack), 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'd0);
    chk("midrst_code", 32'(code), 32'h00);
    chk("midrst_addr", 32'(vram_addr), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("midrst_no_late_ack", 32'(cpu_ack), 32'd0);
    cpu_op(1'b0, 10'd1, 32'd0, 3, 32'h4847_4645, "post_rst_rd");
    chk("post_rst_addr", 32'(addr_seen[1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
